// File: rtl/alu_pkg.sv
// Shared constants for the ALU-sharing arbiter slice.
// Opcodes, FSM encoding and default widths.
package alu_pkg;

  localparam int WIDTH_D = 32;
  localparam int OPW_D   = 4;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_ORR  = 4'b0100;
  localparam logic [3:0] OP_EOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin grant for shared execution units.
// Purely combinational; ties go to the requester not granted last.
module alu_rr_pick (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (1'b1)
      (valid_i == 2'b11): grant_o = last_i ? 2'b01 : 2'b10;
      (valid_i == 2'b01): grant_o = 2'b01;
      (valid_i == 2'b10): grant_o = 2'b10;
      default:            grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between the execute stage (port 0)
// and the address/branch unit (port 1), one op at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int OPW   = OPW_D
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic [WIDTH-1:0] req0_in2,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic [WIDTH-1:0] req1_in2,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [1:0]       grant;
  logic             idle;
  logic             take;
  logic             g;

  alu_rr_pick u_pick (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign idle      = (state_q == S_IDLE);
  assign req_ready = idle ? grant : 2'b00;
  assign take      = |(req_valid & req_ready);
  assign g         = req_ready[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_ISSUE;
          owner_d = g;
          last_d  = g;
          in1_d   = g ? req1_in1 : req0_in1;
          in2_d   = g ? req1_in2 : req0_in2;
          op_d    = g ? req1_op  : req0_op;
        end
      end
      S_ISSUE: state_d = S_COLLECT;
      S_COLLECT: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opcode = op_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign busy       = !idle;
  assign rsp_valid  = (state_q == S_RESP) ?
                      (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a registered ALU model.
// Expected results are hand-computed constants.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_opcode;
  logic        alu_zero;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req0_op    (req0_op),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req1_op    (req1_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_ORR:  return a | b;
      OP_EOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_MOV:  return b;
      OP_CBZ:  return (a == 32'd0) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    alu_result <= alu_f(alu_opcode, alu_in1, alu_in2);
    alu_zero   <= (alu_in1 == 32'd0);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Full transaction; hold = cycles rsp_ready[owner] stays low in RESP.
  task automatic run_op(input string tag, input bit port,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op,
                        input logic [31:0] exp_res, input logic exp_z,
                        input int hold);
    logic [1:0] one;
    one = port ? 2'b10 : 2'b01;
    if (port) begin
      req1_in1 = a; req1_in2 = b; req1_op = op;
    end else begin
      req0_in1 = a; req0_in2 = b; req0_op = op;
    end
    req_valid = one;
    #1 check({tag, " req_ready"}, {30'd0, req_ready}, {30'd0, one});
    step();
    req_valid = 2'b00;
    req0_in1 = 32'hDEAD_BEEF; req1_in1 = 32'hDEAD_BEEF;
    req0_op  = 4'hF;          req1_op  = 4'hF;
    check({tag, " opcode"}, {28'd0, alu_opcode}, {28'd0, op});
    check({tag, " in1"}, alu_in1, a);
    check({tag, " in2"}, alu_in2, b);
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    check({tag, " rv_issue"}, {30'd0, rsp_valid}, 32'd0);
    step();
    check({tag, " rv_collect"}, {30'd0, rsp_valid}, 32'd0);
    step();
    check({tag, " rv_resp"}, {30'd0, rsp_valid}, {30'd0, one});
    check({tag, " result"}, rsp_result, exp_res);
    check({tag, " zero"}, {31'd0, rsp_zero}, {31'd0, exp_z});
    for (int i = 0; i < hold; i++) begin
      rsp_ready = ~one;
      step();
      check({tag, " hold_rv"}, {30'd0, rsp_valid}, {30'd0, one});
      check({tag, " hold_res"}, rsp_result, exp_res);
      check({tag, " hold_busy"}, {31'd0, busy}, 32'd1);
    end
    rsp_ready = one;
    step();
    rsp_ready = 2'b00;
    check({tag, " done_busy"}, {31'd0, busy}, 32'd0);
    check({tag, " done_rv"}, {30'd0, rsp_valid}, 32'd0);
    check({tag, " in1_kept"}, alu_in1, a);
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_r;
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_in1 = '0; req0_in2 = '0; req0_op = '0;
    req1_in1 = '0; req1_in2 = '0; req1_op = '0;
    #3;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst req_ready", {30'd0, req_ready}, 32'd0);
    check("rst alu_in1", alu_in1, 32'd0);
    check("rst alu_opcode", {28'd0, alu_opcode}, 32'd0);
    check("rst rsp_result", rsp_result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    run_op("add0", 1'b0, 32'd15, 32'd15, OP_ADD, 32'd30, 1'b0, 0);
    run_op("sub1", 1'b1, 32'd10, 32'd5, OP_SUB, 32'd5, 1'b0, 5);

    // Both ports requesting continuously: grants must alternate from 0.
    do_reset();
    req0_in1 = 32'd5; req0_in2 = 32'd15; req0_op = OP_AND;
    req1_in1 = 32'd5; req1_in2 = 32'd10; req1_op = OP_ORR;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_r = (t % 2 == 0) ? 32'd5 : 32'd15;
      #1 check("rr grant", {30'd0, req_ready}, {30'd0, exp_g});
      step();
      step();
      step();
      check("rr rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_g});
      check("rr result", rsp_result, exp_r);
      rsp_ready = 2'b11;
      step();
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    #1;

    run_op("cbz0", 1'b0, 32'd0, 32'd3, OP_CBZ, 32'd1, 1'b1, 0);
    run_op("cbz10", 1'b0, 32'd10, 32'd3, OP_CBZ, 32'd0, 1'b0, 1);

    // Reset while the ALU result is in flight.
    req0_in1 = 32'd1; req0_in2 = 32'd2; req0_op = OP_ADD;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async busy", {31'd0, busy}, 32'd0);
    check("async rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("async alu_in1", alu_in1, 32'd0);
    check("async alu_in2", alu_in2, 32'd0);
    check("async opcode", {28'd0, alu_opcode}, 32'd0);
    check("async rsp_result", rsp_result, 32'd0);
    step();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post-rst rsp_valid", {30'd0, rsp_valid}, 32'd0);
    end
    req_valid = 2'b11;
    #1 check("post-rst tie", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    #1;

    run_op("undef", 1'b1, 32'd7, 32'd9, 4'b1111, 32'd0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters: port 0 (execute stage) and port 1 (address/branch unit).
- Round-robin arbitration with valid/ready request and response handshakes.
- Drives the ALU operand and opcode inputs from registers, waits out the ALU's one-clock registered latency, then buffers the result and zero flag until the owner accepts them.
- Sits between the pipeline control and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- WIDTH, 32, operand/result width
- OPW, 4, opcode width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester request accept
- req0_in1, req0_in2  in  WIDTH each  port 0 operands
- req0_op  in  OPW  port 0 opcode
- req1_in1, req1_in2  in  WIDTH each  port 1 operands
- req1_op  in  OPW  port 1 opcode
- alu_in1, alu_in2  out  WIDTH each  registered operands to ALU
- alu_opcode  out  OPW  registered opcode to ALU
- alu_result  in  WIDTH  ALU registered result
- alu_zero  in  1  ALU registered zero flag (inOne==0)
- rsp_valid  out  2  per-requester response valid
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  buffered result
- rsp_zero  out  1  buffered zero flag
- busy  out  1  high in every state except IDLE

Behaviour:

Reset (reset_n low, asynchronous):
- state=IDLE, last_grant=1, owner=0.
- alu_in1/alu_in2/alu_opcode=0, rsp_result=0, rsp_zero=0, rsp_valid=0.
- A transaction in flight is dropped and produces no response. The requester must reissue it.

Arbitration (combinational, IDLE only):
- Only one req_valid high: that requester is granted.
- Both high: the requester != last_grant is granted.
- req_ready[g] is high only in IDLE for the granted g. It is 0 in all other states.

FSM (advances on rising edges):
- IDLE: on req_valid[g] & req_ready[g], latch req_g operands and opcode into alu_* registers, owner<=g, last_grant<=g, go to ISSUE. Otherwise stay.
- ISSUE: alu_* are stable for the whole cycle; the ALU samples at the end of the cycle. Go to COLLECT unconditionally.
- COLLECT: alu_result/alu_zero are valid; capture them into rsp_result/rsp_zero. Go to RESP.
- RESP: rsp_valid[owner]=1, the other bit is 0. On rsp_ready[owner], go to IDLE. Otherwise hold with rsp_* stable.

Latency and throughput:
- Request accepted at edge k means rsp_valid rises in cycle k+3.
- Minimum 4 cycles per operation; there is no overlap between transactions.

Handshake and boundary rules:
- req_valid may drop before acceptance with no effect.
- Operands need not be held after acceptance.
- alu_* keep their last value outside IDLE->ISSUE updates; they are not cleared after RESP.
- rsp_ready on the non-owner bit is ignored.
- A requester may re-request in the same cycle its response is accepted. It is then seen in the next IDLE cycle and arbitration applies normally.
- Opcode values are passed through unchecked. Undefined opcodes return whatever the ALU yields (0).
- No arithmetic is done here. Width is WIDTH throughout with no truncation.

Decomposition:
- Package alu_pkg:
  - opcode constants: ADD=4'b0010, CBZ=4'b0111, SUB=4'b1010, AND=4'b0110, ORR=4'b0100, EOR=4'b1001, NOR=4'b0101, NAND=4'b1100, MOV=4'b1101
  - state encoding: IDLE, ISSUE, COLLECT, RESP
  - WIDTH/OPW defaults
- One sub-module, alu_rr_pick: two-way round-robin grant from req_valid and last_grant. Purely combinational, reused by future shared-unit arbiters.

Test Plan:
- Reset, then port 0 ADD in1=15 in2=15 -> req_ready[0] in the accept cycle; alu_opcode=4'b0010 next cycle; rsp_valid[0] at k+3 with rsp_result=30, rsp_zero=0.
- Port 1 SUB in1=10 in2=5, rsp_ready held low 5 cycles -> rsp_valid[1] and rsp_result=5 stable throughout, busy=1; IDLE one cycle after rsp_ready rises.
- Both valid every cycle after reset (port 0 AND 5&15, port 1 OR 5|10) -> grant order 0,1,0,1; results 5 and 15 delivered to the correct rsp_valid bit.
- CBZ with in1=0 -> rsp_result=1, rsp_zero=1; repeat with in1=10 -> rsp_result=0, rsp_zero=0.
- Assert reset_n low during COLLECT -> all outputs 0 immediately without waiting for a clock edge; no rsp_valid after release; the next request is granted to port 0 on a tie.
- Opcode 4'b1111 -> rsp_result=0 after the normal 3-cycle latency, FSM returns to IDLE.
